// File: rtl/dma_controller.sv
// Byte DMA engine: stalls the CPU, owns the RAM bus and copies SRC->DST for LEN bytes.
// Optional fill mode (constant FILL byte to DST) is built when DMA_FILL_EN is defined.
module dma_controller (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        R_W_n,
    input  logic [2:0]  reg_addr_i,
    input  logic [7:0]  data_i,
    input  logic        dma_cs,
    output logic [7:0]  data_o,
    output logic        cpu_rdy_o,
    output logic        bus_own_o,
    output logic [15:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_data_o,
    input  logic [7:0]  mem_data_i
);

    typedef enum logic [2:0] {IDLE, HOLD, RD, WR, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] src, dst, len;
    logic        fill, done;
    logic        busy, reg_wr, reg_rd, start, fill_bit;

`ifdef DMA_FILL_EN
    logic [7:0]  fill_val;
    assign fill_bit = data_i[1];
`else
    assign fill_bit = 1'b0;
`endif

    assign busy   = (state != IDLE);
    assign reg_wr = dma_cs && !R_W_n && !busy;
    assign reg_rd = dma_cs && R_W_n;
    assign start  = reg_wr && (reg_addr_i == 3'd6) && data_i[0];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            src   <= '0;
            dst   <= '0;
            len   <= '0;
            fill  <= 1'b0;
            done  <= 1'b0;
`ifdef DMA_FILL_EN
            fill_val <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (reg_wr) begin
                case (reg_addr_i)
                    3'd0: src[7:0]  <= data_i;
                    3'd1: src[15:8] <= data_i;
                    3'd2: dst[7:0]  <= data_i;
                    3'd3: dst[15:8] <= data_i;
                    3'd4: len[7:0]  <= data_i;
                    3'd5: len[15:8] <= data_i;
                    3'd6: fill      <= fill_bit;
`ifdef DMA_FILL_EN
                    3'd7: fill_val  <= data_i;
`endif
                    default: ;
                endcase
            end
            // One byte retires per WR cycle; pointers wrap naturally at 16 bits.
            if (state == WR) begin
                if (!fill)
                    src <= src + 16'd1;
                dst <= dst + 16'd1;
                len <= len - 16'd1;
            end
            if (reg_rd && reg_addr_i == 3'd6)
                done <= 1'b0;
            if ((start && len == 16'd0) || state == DONE)
                done <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && len != 16'd0) state_nxt = HOLD;
            HOLD: state_nxt = fill ? WR : RD;
            RD:   state_nxt = WR;
            WR: begin
                if (len == 16'd1)
                    state_nxt = DONE;
                else
                    state_nxt = fill ? WR : RD;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_rdy_o  = (state == IDLE);
        bus_own_o  = (state == RD) || (state == WR);
        mem_we_o   = (state == WR);
        mem_addr_o = '0;
        mem_data_o = '0;
        if (state == RD)
            mem_addr_o = src;
        if (state == WR) begin
            mem_addr_o = dst;
`ifdef DMA_FILL_EN
            mem_data_o = fill ? fill_val : mem_data_i;
`else
            mem_data_o = mem_data_i;
`endif
        end
    end

    always_comb begin
        data_o = '0;
        case (reg_addr_i)
            3'd0: data_o = src[7:0];
            3'd1: data_o = src[15:8];
            3'd2: data_o = dst[7:0];
            3'd3: data_o = dst[15:8];
            3'd4: data_o = len[7:0];
            3'd5: data_o = len[15:8];
            3'd6: data_o = {busy, done, 4'b0000, fill, 1'b0};
`ifdef DMA_FILL_EN
            3'd7: data_o = fill_val;
`endif
            default: data_o = '0;
        endcase
    end

endmodule
